hazard_fwd_ctrl: RTL and testbench

- Next-generation pipeline hazard controller for the 5-stage RISC-V core with SRAM data memory.
- Generates EX-stage operand forwarding selects, plus optional ID-stage register-file bypass.
- Detects load-use hazards and stalls the pipeline while a load waits on the SRAM data-valid handshake.
- Tracks wait time with a timeout error flag and counts stall cycles for performance monitoring.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/fwd_sel.sv | 21 ++
 rtl/hazard_fwd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings, opcode constants and operand-usage decode for the hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      NO_FORWARD  = 2'b00,
      MEM_FORWARD = 2'b01,
      WB_FORWARD  = 2'b10
   } fwd_e;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !((opcode == LUI) || (opcode == AUIPC) || (opcode == JAL));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding source select; MEM result wins over WB result.
module fwd_sel import hazard_pkg::*; (
   input  logic [4:0] i_rs,
   input  logic       i_use,
   input  logic       i_mem_wr,
   input  logic [4:0] i_rd_mem,
   input  logic       i_wb_wr,
   input  logic [4:0] i_rd_wb,
   output fwd_e       o_sel
);

   always_comb begin
      o_sel = NO_FORWARD;
      if (i_use && i_mem_wr && (i_rd_mem != 5'd0) && (i_rd_mem == i_rs)) begin
         o_sel = MEM_FORWARD;
      end else if (i_use && i_wb_wr && (i_rd_wb != 5'd0) && (i_rd_wb == i_rs)) begin
         o_sel = WB_FORWARD;
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard controller: EX forwarding, WB->ID bypass, load-use and SRAM-wait stalls,
// memory timeout flag and saturating stall-cycle counter.
module hazard_fwd_ctrl import hazard_pkg::*; #(
   parameter int unsigned XLEN        = 32,
   parameter bit          RF_BYPASS   = 1'b1,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [XLEN-1:0]  i_instr_id,
   input  logic [XLEN-1:0]  i_instr_ex,
   input  logic [XLEN-1:0]  i_instr_mem,
   input  logic [XLEN-1:0]  i_instr_wb,
   input  logic             i_rd_wren_ex,
   input  logic             i_rd_wren_mem,
   input  logic             i_rd_wren_wb,
   input  logic             i_is_load_ex,
   input  logic             i_is_load_mem,
   input  logic             i_mem_rdata_valid,
   input  logic             i_flush,
   output logic [1:0]       o_forward_asel,
   output logic [1:0]       o_forward_bsel,
   output logic             o_rf_fwd_a,
   output logic             o_rf_fwd_b,
   output logic             o_stall_pc,
   output logic             o_stall_ifid,
   output logic             o_stall_idex,
   output logic             o_stall_exmem,
   output logic             o_bubble_ifid,
   output logic             o_bubble_idex,
   output logic             o_bubble_memwb,
   output logic             o_mem_err,
   output logic [CNT_W-1:0] o_stall_cycles
);

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

   logic [4:0] w_rs1_id, w_rs2_id, w_rd_ex, w_rs1_ex, w_rs2_ex, w_rd_mem, w_rd_wb;
   logic [6:0] w_opc_id;
   logic       w_use_rs1, w_use_rs2;
   logic       w_mem_fwd_ok, w_mem_wait, w_load_use;
   logic       w_byp_a, w_byp_b;
   fwd_e       w_fwd_a, w_fwd_b;
   logic       w_unused;

   assign w_opc_id  = i_instr_id[6:0];
   assign w_rs1_id  = i_instr_id[19:15];
   assign w_rs2_id  = i_instr_id[24:20];
   assign w_rd_ex   = i_instr_ex[11:7];
   assign w_rs1_ex  = i_instr_ex[19:15];
   assign w_rs2_ex  = i_instr_ex[24:20];
   assign w_rd_mem  = i_instr_mem[11:7];
   assign w_rd_wb   = i_instr_wb[11:7];
   assign w_use_rs1 = uses_rs1(w_opc_id);
   assign w_use_rs2 = uses_rs2(w_opc_id);

   assign w_unused = ^{i_instr_id[XLEN-1:25], i_instr_id[14:7], i_instr_ex[XLEN-1:25],
                       i_instr_ex[14:12], i_instr_ex[6:0], i_instr_mem[XLEN-1:12],
                       i_instr_mem[6:0], i_instr_wb[XLEN-1:12], i_instr_wb[6:0]};

   // A load in MEM has no result yet, so it can never be a MEM forwarding source.
   assign w_mem_fwd_ok = i_rd_wren_mem & ~i_is_load_mem;
   assign w_mem_wait   = i_is_load_mem & i_rd_wren_mem & ~i_mem_rdata_valid;
   assign w_load_use   = ~w_mem_wait & ~i_flush & i_is_load_ex & i_rd_wren_ex &
                         (w_rd_ex != 5'd0) &
                         ((w_use_rs1 & (w_rs1_id == w_rd_ex)) |
                          (w_use_rs2 & (w_rs2_id == w_rd_ex)));

   fwd_sel u_fwd_a (
      .i_rs     (w_rs1_ex),
      .i_use    (1'b1),
      .i_mem_wr (w_mem_fwd_ok),
      .i_rd_mem (w_rd_mem),
      .i_wb_wr  (i_rd_wren_wb),
      .i_rd_wb  (w_rd_wb),
      .o_sel    (w_fwd_a)
   );

   fwd_sel u_fwd_b (
      .i_rs     (w_rs2_ex),
      .i_use    (1'b1),
      .i_mem_wr (w_mem_fwd_ok),
      .i_rd_mem (w_rd_mem),
      .i_wb_wr  (i_rd_wren_wb),
      .i_rd_wb  (w_rd_wb),
      .o_sel    (w_fwd_b)
   );

   if (RF_BYPASS) begin : g_rf_bypass
      fwd_e w_id_a, w_id_b;

      fwd_sel u_byp_a (
         .i_rs     (w_rs1_id),
         .i_use    (w_use_rs1),
         .i_mem_wr (1'b0),
         .i_rd_mem (5'd0),
         .i_wb_wr  (i_rd_wren_wb),
         .i_rd_wb  (w_rd_wb),
         .o_sel    (w_id_a)
      );

      fwd_sel u_byp_b (
         .i_rs     (w_rs2_id),
         .i_use    (w_use_rs2),
         .i_mem_wr (1'b0),
         .i_rd_mem (5'd0),
         .i_wb_wr  (i_rd_wren_wb),
         .i_rd_wb  (w_rd_wb),
         .o_sel    (w_id_b)
      );

      assign w_byp_a = (w_id_a == WB_FORWARD);
      assign w_byp_b = (w_id_b == WB_FORWARD);
   end else begin : g_no_rf_bypass
      assign w_byp_a = 1'b0;
      assign w_byp_b = 1'b0;
   end

   state_e           r_state, w_state_d;
   logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_d;
   logic             r_mem_err, w_mem_err_d;
   logic [CNT_W-1:0] r_stall_cycles, w_stall_cycles_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= RUN;
         r_wait_cnt     <= '0;
         r_mem_err      <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         r_state        <= w_state_d;
         r_wait_cnt     <= w_wait_cnt_d;
         r_mem_err      <= w_mem_err_d;
         r_stall_cycles <= w_stall_cycles_d;
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_wait_cnt_d = r_wait_cnt;
      case (r_state)
         RUN: begin
            if (w_mem_wait) begin
               w_state_d    = MEM_WAIT;
               w_wait_cnt_d = WaitW'(1);
            end
         end
         MEM_WAIT: begin
            if (w_mem_wait) begin
               // Hold at the timeout value so the counter never wraps.
               if (r_wait_cnt != WaitW'(MEM_TIMEOUT)) begin
                  w_wait_cnt_d = r_wait_cnt + WaitW'(1);
               end
            end else begin
               w_state_d    = RUN;
               w_wait_cnt_d = '0;
            end
         end
         default: begin
            w_state_d    = RUN;
            w_wait_cnt_d = '0;
         end
      endcase
      w_mem_err_d      = r_mem_err | (w_wait_cnt_d == WaitW'(MEM_TIMEOUT));
      w_stall_cycles_d = r_stall_cycles;
      if (o_stall_pc && (r_stall_cycles != '1)) begin
         w_stall_cycles_d = r_stall_cycles + CNT_W'(1);
      end
   end

   always_comb begin
      o_forward_asel = NO_FORWARD;
      o_forward_bsel = NO_FORWARD;
      o_rf_fwd_a     = 1'b0;
      o_rf_fwd_b     = 1'b0;
      o_stall_pc     = 1'b0;
      o_stall_ifid   = 1'b0;
      o_stall_idex   = 1'b0;
      o_stall_exmem  = 1'b0;
      o_bubble_ifid  = 1'b0;
      o_bubble_idex  = 1'b0;
      o_bubble_memwb = 1'b0;
      if (!i_rst) begin
         o_forward_asel = w_fwd_a;
         o_forward_bsel = w_fwd_b;
         o_rf_fwd_a     = w_byp_a;
         o_rf_fwd_b     = w_byp_b;
         o_stall_pc     = w_mem_wait | w_load_use;
         o_stall_ifid   = w_mem_wait | w_load_use;
         o_stall_idex   = w_mem_wait;
         o_stall_exmem  = w_mem_wait;
         o_bubble_ifid  = i_flush;
         o_bubble_idex  = i_flush | w_load_use;
         o_bubble_memwb = w_mem_wait;
      end
   end

   assign o_mem_err      = r_mem_err;
   assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl with hand-computed expectations.
module tb_hazard_fwd_ctrl;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] instr_id, instr_ex, instr_mem, instr_wb;
   logic        rd_wren_ex, rd_wren_mem, rd_wren_wb;
   logic        is_load_ex, is_load_mem, mem_rdata_valid, flush;
   logic [1:0]  fwd_a, fwd_b;
   logic        rf_a, rf_b;
   logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
   logic        bubble_ifid, bubble_idex, bubble_memwb;
   logic        mem_err;
   logic [3:0]  stall_cycles;

   int n_checks = 0;
   int n_errors = 0;

   hazard_fwd_ctrl #(
      .XLEN        (32),
      .RF_BYPASS   (1'b1),
      .MEM_TIMEOUT (4),
      .CNT_W       (4)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_instr_id        (instr_id),
      .i_instr_ex        (instr_ex),
      .i_instr_mem       (instr_mem),
      .i_instr_wb        (instr_wb),
      .i_rd_wren_ex      (rd_wren_ex),
      .i_rd_wren_mem     (rd_wren_mem),
      .i_rd_wren_wb      (rd_wren_wb),
      .i_is_load_ex      (is_load_ex),
      .i_is_load_mem     (is_load_mem),
      .i_mem_rdata_valid (mem_rdata_valid),
      .i_flush           (flush),
      .o_forward_asel    (fwd_a),
      .o_forward_bsel    (fwd_b),
      .o_rf_fwd_a        (rf_a),
      .o_rf_fwd_b        (rf_b),
      .o_stall_pc        (stall_pc),
      .o_stall_ifid      (stall_ifid),
      .o_stall_idex      (stall_idex),
      .o_stall_exmem     (stall_exmem),
      .o_bubble_ifid     (bubble_ifid),
      .o_bubble_idex     (bubble_idex),
      .o_bubble_memwb    (bubble_memwb),
      .o_mem_err         (mem_err),
      .o_stall_cycles    (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, OPC_OP};
   endfunction

   function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'd0, rs1, 3'b010, rd, OPC_LOAD};
   endfunction

   function automatic logic [31:0] enc_sw(input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b010, 5'd0, OPC_STORE};
   endfunction

   function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, OPC_LUI};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr_id = NOP; instr_ex = NOP; instr_mem = NOP; instr_wb = NOP;
      rd_wren_ex = 1'b0; rd_wren_mem = 1'b0; rd_wren_wb = 1'b0;
      is_load_ex = 1'b0; is_load_mem = 1'b0; mem_rdata_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   // LW x5 sitting in MEM, waiting on SRAM
   task automatic mem_load();
      instr_mem = enc_lw(5'd5, 5'd1); is_load_mem = 1'b1; rd_wren_mem = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      // Forwarding, bypass and flush patterns applied while reset is held
      instr_ex = enc_r(5'd3, 5'd1, 5'd2);
      instr_mem = enc_r(5'd1, 5'd4, 5'd4); rd_wren_mem = 1'b1;
      instr_wb = enc_r(5'd2, 5'd4, 5'd4); rd_wren_wb = 1'b1;
      instr_id = enc_r(5'd6, 5'd2, 5'd9);
      flush = 1'b1;
      #1;
      check("rst_fwd_a", fwd_a, 0);
      check("rst_fwd_b", fwd_b, 0);
      check("rst_rf_a", rf_a, 0);
      check("rst_bubble_ifid", bubble_ifid, 0);
      tick(); tick();
      check("rst_stall_cycles", stall_cycles, 0);
      check("rst_mem_err", mem_err, 0);

      rst = 1'b0; flush = 1'b0; #1;
      check("fwd_a_mem", fwd_a, 1);
      check("fwd_b_wb", fwd_b, 2);
      check("rf_a_wb", rf_a, 1);
      check("rf_b_none", rf_b, 0);
      instr_mem = enc_r(5'd0, 5'd4, 5'd4); #1;
      check("fwd_a_rd0", fwd_a, 0);
      check("fwd_b_rd0", fwd_b, 2);
      instr_mem = enc_r(5'd1, 5'd4, 5'd4); instr_wb = enc_r(5'd1, 5'd4, 5'd4); #1;
      check("fwd_a_prio", fwd_a, 1);
      check("fwd_b_nomatch", fwd_b, 0);
      is_load_mem = 1'b1; mem_rdata_valid = 1'b1; #1;
      check("fwd_a_load_mem", fwd_a, 2);
      is_load_mem = 1'b0; mem_rdata_valid = 1'b0;

      // WB->ID bypass
      idle();
      instr_wb = enc_r(5'd9, 5'd4, 5'd4); rd_wren_wb = 1'b1;
      instr_id = enc_r(5'd6, 5'd2, 5'd9); #1;
      check("rf_a_nomatch", rf_a, 0);
      check("rf_b_wb", rf_b, 1);
      instr_id = enc_lui(5'd6, 20'h00048); #1;
      check("rf_a_lui_unused", rf_a, 0);
      check("rf_b_lui_unused", rf_b, 0);
      instr_id = enc_sw(5'd9, 5'd9); rd_wren_wb = 1'b0; #1;
      check("rf_a_nowren", rf_a, 0);

      // Load-use
      idle();
      instr_ex = enc_lw(5'd5, 5'd1); is_load_ex = 1'b1; rd_wren_ex = 1'b1;
      instr_id = enc_r(5'd6, 5'd5, 5'd7); #1;
      check("lu_stall_pc", stall_pc, 1);
      check("lu_stall_ifid", stall_ifid, 1);
      check("lu_bubble_idex", bubble_idex, 1);
      check("lu_stall_idex", stall_idex, 0);
      check("lu_bubble_ifid", bubble_ifid, 0);
      tick();
      check("lu_stall_cycles", stall_cycles, 1);
      instr_ex = NOP; is_load_ex = 1'b0; rd_wren_ex = 1'b0;
      mem_load(); mem_rdata_valid = 1'b1; #1;
      check("lu_after_stall_pc", stall_pc, 0);
      check("lu_after_bubble_idex", bubble_idex, 0);
      tick();
      check("lu_after_cycles", stall_cycles, 1);
      idle();
      instr_ex = enc_lw(5'd5, 5'd1); is_load_ex = 1'b1; rd_wren_ex = 1'b1;
      instr_id = enc_lui(5'd6, 20'h00028); #1;
      check("lu_lui_no_stall", stall_pc, 0);
      instr_id = enc_sw(5'd7, 5'd5); #1;
      check("lu_store_rs2", stall_pc, 1);
      instr_ex = enc_lw(5'd0, 5'd1); #1;
      check("lu_rd0", stall_pc, 0);

      // SRAM wait: three cycles without valid
      do_reset();
      mem_load();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("mw_stall_pc", stall_pc, 1);
         check("mw_stall_idex", stall_idex, 1);
         check("mw_stall_exmem", stall_exmem, 1);
         check("mw_bubble_memwb", bubble_memwb, 1);
         tick();
      end
      check("mw_cycles3", stall_cycles, 3);
      mem_rdata_valid = 1'b1; #1;
      check("mw_valid_stall_pc", stall_pc, 0);
      check("mw_valid_bubble_memwb", bubble_memwb, 0);
      tick();
      check("mw_cycles_hold", stall_cycles, 3);
      mem_rdata_valid = 1'b0;
      tick(); tick(); tick();
      mem_rdata_valid = 1'b1;
      tick();
      check("mw_second_no_err", mem_err, 0);
      check("mw_cycles6", stall_cycles, 6);

      // Flush during a wait, with a load-use pattern present
      mem_rdata_valid = 1'b0; flush = 1'b1;
      instr_ex = enc_lw(5'd5, 5'd1); is_load_ex = 1'b1; rd_wren_ex = 1'b1;
      instr_id = enc_r(5'd6, 5'd5, 5'd7); #1;
      check("fl_stall_pc", stall_pc, 1);
      check("fl_stall_idex", stall_idex, 1);
      check("fl_stall_exmem", stall_exmem, 1);
      check("fl_bubble_ifid", bubble_ifid, 1);
      check("fl_bubble_idex", bubble_idex, 1);
      check("fl_bubble_memwb", bubble_memwb, 1);
      tick();
      flush = 1'b0; #1;
      check("fl_masked_stall_pc", stall_pc, 1);
      check("fl_masked_bubble_idex", bubble_idex, 0);
      tick();
      mem_rdata_valid = 1'b1; flush = 1'b1; #1;
      check("fl_valid_stall_pc", stall_pc, 0);
      check("fl_valid_bubble_idex", bubble_idex, 1);
      check("fl_valid_stall_idex", stall_idex, 0);
      tick();
      flush = 1'b0; instr_ex = NOP; is_load_ex = 1'b0; rd_wren_ex = 1'b0; #1;
      check("fl_after_stall_pc", stall_pc, 0);
      tick();
      check("fl_cycles8", stall_cycles, 8);
      check("fl_no_err", mem_err, 0);

      // Timeout with MEM_TIMEOUT=4, then counter saturation
      do_reset();
      mem_load();
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("to_err", mem_err, (k >= 4) ? 1 : 0);
      end
      #1;
      check("to_stall_continues", stall_pc, 1);
      check("to_cycles6", stall_cycles, 6);
      for (int k = 0; k < 12; k++) tick();
      check("sat_cycles", stall_cycles, 15);
      mem_rdata_valid = 1'b1;
      tick();
      check("to_err_sticky", mem_err, 1);

      // Reset in the middle of a wait
      mem_rdata_valid = 1'b0;
      tick(); tick();
      rst = 1'b1; #1;
      check("rm_stall_pc", stall_pc, 0);
      check("rm_stall_exmem", stall_exmem, 0);
      check("rm_bubble_memwb", bubble_memwb, 0);
      tick();
      check("rm_cycles", stall_cycles, 0);
      check("rm_err", mem_err, 0);
      rst = 1'b0; #1;
      check("rm_resume_stall", stall_pc, 1);
      tick(); tick(); tick();
      check("rm_err_cnt3", mem_err, 0);
      tick();
      check("rm_err_cnt4", mem_err, 1);
      check("rm_cycles4", stall_cycles, 4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
